// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
// Shared definitions for the Pac-Man motion logic: the heading type, the maze
// geometry (tile size and grid dimensions) and the default start position.
// Ports: none (package).
// -----------------------------------------------------------------------------
package pacman_pkg;

    // Heading encoding; the numeric values are visible on dir_cur.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int unsigned TILE_PX     = 10;
    localparam int unsigned GRID_W      = 28;
    localparam int unsigned GRID_H      = 31;
    localparam int unsigned START_X_DEF = 145;
    localparam int unsigned START_Y_DEF = 235;

    // Fixed button priority when several are held: UP > DOWN > LEFT > RIGHT.
    function automatic dir_t dir_priority(input logic up, input logic down,
                                          input logic left);
        if (up)
            return DIR_UP;
        else if (down)
            return DIR_DOWN;
        else if (left)
            return DIR_LEFT;
        else
            return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/pacman_motion_ctrl.sv
// -----------------------------------------------------------------------------
// pacman_motion_ctrl
// Moves Pac-Man one pixel per accepted move_tick. Button presses are buffered
// as a pending turn request; each evaluation first tries the buffered turn,
// then the current heading, otherwise Pac-Man stops.
//
// Optional build macro: PACMAN_TUNNEL_WRAP_EN -- when defined, stepping off the
// left/right edge wraps to the opposite edge (tunnel), ignoring can_left/right.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   move_tick               one-cycle strobe, permits one pixel step
//   btn_up/down/left/right  debounced direction requests (level)
//   can_up/down/left/right  collision lookup for the current position
//   x_pos_pixel/y_pos_pixel current position (UP increases y)
//   dir_cur                 current heading (0 UP, 1 DOWN, 2 LEFT, 3 RIGHT)
//   moving                  last evaluation produced a step
//   req_pending             a buffered turn request is held
// -----------------------------------------------------------------------------
module pacman_motion_ctrl
    import pacman_pkg::*;
#(
    parameter int unsigned START_X = START_X_DEF,
    parameter int unsigned START_Y = START_Y_DEF,
    parameter int unsigned X_MAX   = GRID_W * TILE_PX - 1,
    parameter int unsigned Y_MAX   = GRID_H * TILE_PX - 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       can_up,
    input  logic       can_down,
    input  logic       can_left,
    input  logic       can_right,
    output logic [8:0] x_pos_pixel,
    output logic [8:0] y_pos_pixel,
    output logic [1:0] dir_cur,
    output logic       moving,
    output logic       req_pending
);

    localparam logic [8:0] X_MAX_PX   = 9'(X_MAX);
    localparam logic [8:0] Y_MAX_PX   = 9'(Y_MAX);
    localparam logic [8:0] START_X_PX = 9'(START_X);
    localparam logic [8:0] START_Y_PX = 9'(START_Y);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_EVAL = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [8:0] x_q, x_next;
    logic [8:0] y_q, y_next;
    dir_t       dir_q, dir_next;
    dir_t       req_dir, req_dir_next;
    logic       moving_q, moving_next;
    logic       pend_q, pend_next;

    logic [3:0] step_ok;
    logic       do_step;
    dir_t       step_dir;
    logic [8:0] x_stepped;
    logic [8:0] y_stepped;

    assign x_pos_pixel = x_q;
    assign y_pos_pixel = y_q;
    assign dir_cur     = dir_q;
    assign moving      = moving_q;
    assign req_pending = pend_q;

    // Whether a one-pixel step in each direction is allowed from here. The y
    // bounds override can_*; the x edges either block or wrap by build option.
    always_comb begin
        step_ok            = '0;
        step_ok[DIR_UP]    = can_up   && (y_q != Y_MAX_PX);
        step_ok[DIR_DOWN]  = can_down && (y_q != 9'd0);
`ifdef PACMAN_TUNNEL_WRAP_EN
        step_ok[DIR_LEFT]  = can_left  || (x_q == 9'd0);
        step_ok[DIR_RIGHT] = can_right || (x_q == X_MAX_PX);
`else
        step_ok[DIR_LEFT]  = can_left  && (x_q != 9'd0);
        step_ok[DIR_RIGHT] = can_right && (x_q != X_MAX_PX);
`endif
    end

    // Evaluation decision: buffered turn first, then keep going, else stop.
    always_comb begin
        do_step  = 1'b0;
        step_dir = dir_q;
        if (pend_q && step_ok[req_dir]) begin
            do_step  = 1'b1;
            step_dir = req_dir;
        end else if (step_ok[dir_q]) begin
            do_step  = 1'b1;
            step_dir = dir_q;
        end
    end

    // Position after one step in step_dir. The x edge cases are only reached
    // when wrapping is enabled, since step_ok blocks them otherwise.
    always_comb begin
        x_stepped = x_q;
        y_stepped = y_q;
        case (step_dir)
            DIR_UP:    y_stepped = y_q + 9'd1;
            DIR_DOWN:  y_stepped = y_q - 9'd1;
            DIR_LEFT:  x_stepped = (x_q == 9'd0) ? X_MAX_PX : x_q - 9'd1;
            DIR_RIGHT: x_stepped = (x_q == X_MAX_PX) ? 9'd0 : x_q + 9'd1;
            default:   x_stepped = x_q;
        endcase
    end

    // Next-state logic. A tick seen while in EVAL is dropped because EVAL
    // always returns to WAIT. Button loading comes last so that a press in
    // the EVAL cycle survives the clear from a taken turn and is used next time.
    always_comb begin
        state_next   = state;
        x_next       = x_q;
        y_next       = y_q;
        dir_next     = dir_q;
        req_dir_next = req_dir;
        moving_next  = moving_q;
        pend_next    = pend_q;

        case (state)
            ST_WAIT: begin
                if (move_tick)
                    state_next = ST_EVAL;
            end
            ST_EVAL: begin
                state_next  = ST_WAIT;
                moving_next = do_step;
                if (do_step) begin
                    x_next   = x_stepped;
                    y_next   = y_stepped;
                    dir_next = step_dir;
                end
                if (pend_q && step_ok[req_dir])
                    pend_next = 1'b0;
            end
            default: state_next = ST_WAIT;
        endcase

        if (btn_up || btn_down || btn_left || btn_right) begin
            req_dir_next = dir_priority(btn_up, btn_down, btn_left);
            pend_next    = 1'b1;
        end
    end

    // State and datapath registers; reset wins over everything in its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_WAIT;
            x_q      <= START_X_PX;
            y_q      <= START_Y_PX;
            dir_q    <= DIR_LEFT;
            req_dir  <= DIR_LEFT;
            moving_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state    <= state_next;
            x_q      <= x_next;
            y_q      <= y_next;
            dir_q    <= dir_next;
            req_dir  <= req_dir_next;
            moving_q <= moving_next;
            pend_q   <= pend_next;
        end
    end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pacman_motion_ctrl
// Directed scenarios followed by random traffic, all compared against a
// behavioural model of Pac-Man's movement rules.
// -----------------------------------------------------------------------------
module tb_pacman_motion_ctrl;

    localparam int X_MAX = 279;
    localparam int Y_MAX = 309;
`ifdef PACMAN_TUNNEL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       move_tick;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       can_up, can_down, can_left, can_right;
    logic [8:0] x_pos_pixel, y_pos_pixel;
    logic [1:0] dir_cur;
    logic       moving, req_pending;

    int total = 0;
    int bad   = 0;

    // Model state: position, heading, buffered request, last-step flag and
    // whether an evaluation is scheduled for the next edge.
    int mx, my, mdir, mreq, mmov, mpend, msched;
    int DX[4] = '{0, 0, -1, 1};
    int DY[4] = '{1, -1, 0, 0};

    pacman_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .move_tick  (move_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .can_up     (can_up),
        .can_down   (can_down),
        .can_left   (can_left),
        .can_right  (can_right),
        .x_pos_pixel(x_pos_pixel),
        .y_pos_pixel(y_pos_pixel),
        .dir_cur    (dir_cur),
        .moving     (moving),
        .req_pending(req_pending)
    );

    always #5 clk = ~clk;

    // Attempt a step in heading d from the model position.
    function automatic bit try_step(input int d, output int nx, output int ny);
        bit wrapped;
        bit [3:0] cv;
        cv = {can_right, can_left, can_down, can_up};
        wrapped = 1'b0;
        nx = mx + DX[d];
        ny = my + DY[d];
        if (WRAP && nx < 0) begin nx = X_MAX; wrapped = 1'b1; end
        if (WRAP && nx > X_MAX) begin nx = 0; wrapped = 1'b1; end
        if (nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX)
            return 1'b0;
        return cv[d] || wrapped;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int nx, ny;
        if (reset) begin
            mx = 145; my = 235; mdir = 2; mreq = 2;
            mmov = 0; mpend = 0; msched = 0;
        end else begin
            if (msched != 0) begin
                if (mpend != 0 && try_step(mreq, nx, ny)) begin
                    mx = nx; my = ny; mdir = mreq; mpend = 0; mmov = 1;
                end else if (try_step(mdir, nx, ny)) begin
                    mx = nx; my = ny; mmov = 1;
                end else begin
                    mmov = 0;
                end
                msched = 0;
            end else begin
                msched = move_tick ? 1 : 0;
            end
            if (btn_up || btn_down || btn_left || btn_right) begin
                mreq  = btn_up ? 0 : btn_down ? 1 : btn_left ? 2 : 3;
                mpend = 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, ".x"},    32'(x_pos_pixel), mx);
        check({tag, ".y"},    32'(y_pos_pixel), my);
        check({tag, ".dir"},  32'(dir_cur),     mdir);
        check({tag, ".mov"},  32'(moving),      mmov);
        check({tag, ".pend"}, 32'(req_pending), mpend);
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic apply_stimulus(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    task automatic pulse_tick(input string tag);
        move_tick = 1'b1;
        apply_stimulus(tag);
        move_tick = 1'b0;
        apply_stimulus(tag);
    endtask

    task automatic set_can(input logic u, input logic d, input logic l, input logic r);
        can_up = u; can_down = d; can_left = l; can_right = r;
    endtask

    initial begin
        int steps;
        reset = 1'b1; move_tick = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        set_can(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state.
        apply_stimulus("reset");
        apply_stimulus("reset");
        check("rst_x", 32'(x_pos_pixel), 145);
        check("rst_y", 32'(y_pos_pixel), 235);
        check("rst_dir", 32'(dir_cur), 2);
        reset = 1'b0;
        apply_stimulus("idle");

        // Three ticks heading left along an open corridor.
        set_can(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse_tick("walk");
            check("walk_x", 32'(x_pos_pixel), 144 - i);
            check("walk_mov", 32'(moving), 1);
        end

        // Buffered UP turn held until the opening appears.
        btn_up = 1'b1;
        apply_stimulus("btn_up");
        btn_up = 1'b0;
        pulse_tick("buf");
        pulse_tick("buf");
        check("buf_x", 32'(x_pos_pixel), 140);
        check("buf_pend", 32'(req_pending), 1);
        set_can(1'b1, 1'b0, 1'b1, 1'b0);
        pulse_tick("turn");
        check("turn_y", 32'(y_pos_pixel), 236);
        check("turn_dir", 32'(dir_cur), 0);
        check("turn_pend", 32'(req_pending), 0);

        // Blocked with no request, then a reversal-style turn to the right.
        set_can(1'b0, 1'b0, 1'b0, 1'b0);
        pulse_tick("stop");
        check("stop_mov", 32'(moving), 0);
        check("stop_x", 32'(x_pos_pixel), 140);
        btn_right = 1'b1;
        apply_stimulus("btn_right");
        btn_right = 1'b0;
        set_can(1'b0, 1'b0, 1'b0, 1'b1);
        pulse_tick("right");
        check("right_x", 32'(x_pos_pixel), 141);
        check("right_dir", 32'(dir_cur), 3);

        // Walk left to the edge of the screen, then one more tick at x=0.
        btn_left = 1'b1;
        apply_stimulus("btn_left");
        btn_left = 1'b0;
        set_can(1'b0, 1'b0, 1'b1, 1'b0);
        steps = 0;
        while (mx != 0 && steps < 400) begin
            pulse_tick("edge_walk");
            steps++;
        end
        check("edge_reached", 32'(x_pos_pixel), 0);
        pulse_tick("edge");
        check("edge_x", 32'(x_pos_pixel), WRAP ? 279 : 0);
        check("edge_mov", 32'(moving), WRAP ? 1 : 0);

        // Simultaneous buttons, tick held into EVAL, reset during EVAL.
        reset = 1'b1;
        apply_stimulus("rst2");
        reset = 1'b0;
        btn_up = 1'b1; btn_left = 1'b1;
        apply_stimulus("both");
        btn_up = 1'b0; btn_left = 1'b0;
        set_can(1'b1, 1'b0, 1'b1, 1'b0);
        move_tick = 1'b1;
        apply_stimulus("hold");
        apply_stimulus("hold");
        move_tick = 1'b0;
        apply_stimulus("hold");
        apply_stimulus("hold");
        check("hold_y", 32'(y_pos_pixel), 236);
        check("hold_x", 32'(x_pos_pixel), 145);
        check("hold_dir", 32'(dir_cur), 0);
        move_tick = 1'b1;
        apply_stimulus("pre_rst");
        move_tick = 1'b0;
        reset = 1'b1;
        apply_stimulus("rst_eval");
        reset = 1'b0;
        check("rst_eval_y", 32'(y_pos_pixel), 235);
        check("rst_eval_pend", 32'(req_pending), 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            move_tick = ($urandom_range(0, 2) == 0);
            btn_up    = ($urandom_range(0, 11) == 0);
            btn_down  = ($urandom_range(0, 11) == 0);
            btn_left  = ($urandom_range(0, 11) == 0);
            btn_right = ($urandom_range(0, 11) == 0);
            set_can($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            apply_stimulus("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pacman_motion_ctrl.md
PACMAN_MOTION_CTRL -- requirements
Module: pacman_motion_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  START_X 145 reset x pixel; START_Y 235 reset y pixel; X_MAX 279 rightmost x pixel (28 tiles x 10 px - 1); Y_MAX 309 topmost y pixel (31 tiles x 10 px - 1).
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single system clock; all logic on rising edge.
  reset  in  1  synchronous, active-high reset.
  move_tick  in  1  one-cycle strobe; each strobe permits one pixel step.
  btn_up / btn_down / btn_left / btn_right  in  1 each  player direction request, level, already debounced.
  can_up / can_down / can_left / can_right  in  1 each  collision-lookup result for the current x_pos_pixel/y_pos_pixel; combinational, valid one cycle after the position changes.
  x_pos_pixel  out  9  current x pixel.
  y_pos_pixel  out  9  current y pixel; UP increases y.
  dir_cur  out  2  current heading: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
  moving  out  1  1 while the last evaluation produced a step.
  req_pending  out  1  1 while a buffered request is held.
REQ-003 All outputs registered; no combinational path from any input to any output.

Function
REQ-004 FSM states WAIT and EVAL; EVAL lasts exactly one cycle; WAIT->EVAL on move_tick; EVAL->WAIT unconditionally.
REQ-005 move_tick asserted during EVAL is ignored; it is not queued.
REQ-006 Request buffer: any asserted btn_* loads req_dir and sets req_pending; priority on simultaneous buttons UP>DOWN>LEFT>RIGHT; a newer press overwrites the buffer.
REQ-007 Buffer is sampled registered: a press in the same cycle as EVAL affects only the next EVAL.
REQ-008 In EVAL, first match wins: (a) req_pending and can_<req_dir> -> dir_cur<=req_dir, clear req_pending, step in req_dir; (b) else can_<dir_cur> -> step in dir_cur, keep buffer; (c) else no step, moving<=0, buffer held.
REQ-009 Step = +/-1 pixel on one axis; moving<=1 on any step; position updates at the EVAL clock edge; total latency move_tick to new position is 2 cycles.
REQ-010 A request opposite to dir_cur is legal and follows REQ-008 (reversal is immediate when can_* allows).
REQ-011 y bounds: never step below 0 or above Y_MAX; at a bound, treat as case (c) regardless of can_*.
REQ-012 x bound behaviour is given in REQ-016/017.

Reset
REQ-013 While reset=1 at a clock edge: state<=WAIT, x_pos_pixel<=START_X, y_pos_pixel<=START_Y, dir_cur<=LEFT, moving<=0, req_pending<=0, req_dir<=LEFT.
REQ-014 Reset overrides move_tick and buttons in the same cycle; reset during EVAL discards that evaluation.
REQ-015 First EVAL after reset is triggered by the first move_tick received with reset=0.

Configuration
REQ-016 With macro PACMAN_TUNNEL_WRAP_EN defined: stepping LEFT from x=0 sets x=X_MAX and stepping RIGHT from x=X_MAX sets x=0; the wrap step is taken regardless of can_left/can_right.
REQ-017 Without PACMAN_TUNNEL_WRAP_EN: x=0 moving LEFT or x=X_MAX moving RIGHT is treated as case (c); x never leaves 0..X_MAX.

Structure
REQ-018 Shared package pacman_pkg holds typedef dir_t (UP/DOWN/LEFT/RIGHT, 2 bits), the tile-size constant 10, the grid dimensions 28 and 31, and the START_X/START_Y defaults.
REQ-019 No sub-module is required; the FSM, buffer and position registers are contained in one module; move_tick generation is external.

Verification
REQ-020 Reset then 3 ticks with can_left=1 and no buttons -> x=145,144,143,142 successively, y=235, dir_cur=LEFT, moving=1.
REQ-021 btn_up pulse while can_up=0 and can_left=1; 2 ticks -> x decreases by 2, req_pending stays 1; set can_up=1, 1 tick -> y=236, dir_cur=UP, req_pending=0.
REQ-022 can_<dir_cur>=0 and no request, tick -> position unchanged, moving=0; then btn_right with can_right=1, tick -> x+1, dir_cur=RIGHT, moving=1.
REQ-023 x=0, dir LEFT, tick: with PACMAN_TUNNEL_WRAP_EN -> x=279; without it -> x=0, moving=0.
REQ-024 btn_up and btn_left together -> req_dir=UP; tick asserted in the EVAL cycle -> exactly one step; reset asserted during EVAL -> x=145, y=235, req_pending=0 next cycle.
